mem_read_ctrl: RTL and testbench

MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

---
 rtl/mem_read_ctrl.sv | 85 ++++++++
 tb/tb_mem_read_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_read_ctrl.sv
// Single-outstanding memory read controller: accepts a request in IDLE, holds the
// read strobe until the memory answers or a cycle budget expires, then pulses done.
module mem_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Wide enough to hold TIMEOUT-1; a one-bit stub when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      data_out <= '0;
      mem_addr <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (req) begin
            mem_addr <= addr_in;
            cnt      <= '0;
            state    <= READ;
          end
        end
        READ: begin
          // A ready response takes precedence over an expiring budget on the same edge.
          if (mem_ready) begin
            data_out <= mem_rdata;
            err_q    <= 1'b0;
            state    <= DONE;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (TIMEOUT_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode registered state only; no input reaches them combinationally.
  assign mem_rd = (state == READ);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign err    = err_q;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Randomized scoreboard bench for mem_read_ctrl: the driver queues the expected
// outcome of each read, and an independent monitor checks every done pulse.
module tb_mem_read_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          err;

  mem_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .addr_in(addr_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .data_out(data_out), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    int            rd_cycles;
    int            done_cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_data = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  int rd_cnt = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!busy) rd_cnt = 0;
    if (mem_rd) begin
      rd_cnt++;
      if (sb.size() > 0) chk("mem_addr_stable", mem_addr, sb[0].addr);
    end
    if (err && !done) chk("err_without_done", err, 1'b0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("data_out", data_out, e.data);
        chk("err", err, e.err);
        chk("mem_addr_done", mem_addr, e.addr);
        chk("mem_rd_cycles", rd_cnt, e.rd_cycles);
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete read; delay >= TO means the memory never answers.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int delay, input bit junk);
    exp_t e;
    bit   answers;
    answers     = (delay < TO);
    e.addr      = a;
    e.err       = !answers;
    e.data      = answers ? d : model_data;
    e.rd_cycles = answers ? delay + 1 : TO;
    e.done_cyc  = cyc + 1 + e.rd_cycles;
    sb.push_back(e);
    if (answers) model_data = d;
    reset   = 1'b0;
    req     = 1'b1;
    addr_in = a;
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < e.rd_cycles; i++) begin
      mem_ready = answers && (i == delay);
      mem_rdata = mem_ready ? d : DW'($urandom);
      req       = junk ? 1'($urandom) : 1'b0;
      addr_in   = AW'($urandom);
      step();
    end
    req       = junk ? 1'b1 : 1'b0;
    addr_in   = AW'($urandom);
    mem_ready = 1'($urandom);
    mem_rdata = DW'($urandom);
    step();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      addr_in   = AW'($urandom);
      step();
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_data_out"}, data_out, '0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with req high: the request must not be taken.
    reset     = 1'b1;
    req       = 1'b1;
    addr_in   = 8'h2A;
    mem_ready = 1'b1;
    mem_rdata = 8'h00;
    repeat (3) step();
    check_quiet("reset");

    // Basic read, released from reset with req still high.
    do_read(8'h2A, 8'hC3, 0, 1'b0);
    idle(1);
    // Timeout keeps the previous data.
    do_read(8'h51, 8'h77, TO, 1'b0);
    idle(2);
    // Wait states.
    do_read(8'h90, 8'h5E, 4, 1'b0);
    idle(1);
    // Ready arrives on the timeout edge.
    do_read(8'h13, 8'hA5, TO - 1, 1'b0);
    idle(1);

    // Reset on the second READ cycle, with ready also high on that edge.
    req     = 1'b1;
    addr_in = 8'h66;
    mem_ready = 1'b0;
    step();
    req       = 1'b0;
    mem_ready = 1'b0;
    step();
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 8'hFF;
    step();
    check_quiet("abort");
    reset      = 1'b0;
    model_data = '0;
    idle(2);

    // req held high with addr changing every cycle: one accept per 3 cycles.
    for (int i = 0; i < 6; i++) do_read(AW'($urandom), DW'($urandom), 0, 1'b1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      do_read(AW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 2)),
              1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
